// File: rtl/sram_dp_be.sv
// One-write/one-read flip-flop memory with per-byte write enables, registered
// read, write-first bypass on address collision and a post-reset zeroing sweep.
module sram_dp_be #(
  parameter int  DW    = 32,
  parameter int  AW    = 3,
  localparam int NB    = DW / 8,
  localparam int DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [NB-1:0] wbe,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd,
  output logic          rvalid,
  output logic          ready
);

  if (DW % 8 != 0) begin : g_dw_check
    $error("sram_dp_be: DW must be a multiple of 8");
  end

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          rvalid_q, rvalid_d;
  logic          clr_en;
  logic          wr_en;
  logic [DW-1:0] byp_data;

  logic [DW-1:0] mem [DEPTH];

  // Write-first: lanes being written to the address being read show the new data.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      byp_data[8*i +: 8] = (we && wbe[i] && (waddr == raddr)) ? wd[8*i +: 8]
                                                              : mem[raddr][8*i +: 8];
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rd_d       = rd_q;
    rvalid_d   = 1'b0;
    clr_en     = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        wr_en = we;
        if (re) begin
          rd_d     = byp_data;
          rvalid_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      rd_q       <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_q       <= rd_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // NOTE: the array has no reset branch; the CLEAR sweep zeroes it instead,
  // which keeps the storage as plain enable flops.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (clr_en) begin
        mem[clr_addr_q] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (wbe[i]) begin
            mem[waddr][8*i +: 8] <= wd[8*i +: 8];
          end
        end
      end
    end
  end

  assign rd     = rd_q;
  assign rvalid = rvalid_q;
  assign ready  = (state_q == RUN);

endmodule

// File: tb/tb_sram_dp_be.sv
// Scoreboard bench for sram_dp_be: a behavioural memory model predicts each
// read result, queues it when the read is issued and compares when rvalid shows.
module tb_sram_dp_be;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          we     = 1'b0;
  logic [NB-1:0] wbe    = '0;
  logic [AW-1:0] waddr  = '0;
  logic [DW-1:0] wd     = '0;
  logic          re     = 1'b0;
  logic [AW-1:0] raddr  = '0;
  logic [DW-1:0] rd;
  logic          rvalid;
  logic          ready;

  sram_dp_be #(.DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .we     (we),
    .wbe    (wbe),
    .waddr  (waddr),
    .wd     (wd),
    .re     (re),
    .raddr  (raddr),
    .rd     (rd),
    .rvalid (rvalid),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] mmem [DEPTH];
  logic          mready     = 1'b0;
  int            mcnt       = 0;
  logic          exp_rvalid = 1'b0;
  logic [DW-1:0] last_rd    = '0;
  logic [DW-1:0] sbq [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model across the same edge, then compare.
  task automatic cyc(input logic rst_v, input logic we_v, input logic [NB-1:0] wbe_v,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wdv,
                     input logic re_v, input logic [AW-1:0] ra);
    logic [DW-1:0] e;
    resetn = rst_v;
    we     = we_v;
    wbe    = wbe_v;
    waddr  = wa;
    wd     = wdv;
    re     = re_v;
    raddr  = ra;
    if (!rst_v) begin
      mready     = 1'b0;
      mcnt       = 0;
      exp_rvalid = 1'b0;
      last_rd    = '0;
    end else if (!mready) begin
      mmem[mcnt] = '0;
      if (mcnt == DEPTH - 1) mready = 1'b1;
      mcnt++;
      exp_rvalid = 1'b0;
    end else begin
      exp_rvalid = re_v;
      if (re_v) begin
        e = mmem[ra];
        if (we_v && wa == ra)
          for (int i = 0; i < NB; i++) if (wbe_v[i]) e[8*i +: 8] = wdv[8*i +: 8];
        sbq.push_back(e);
      end
      if (we_v)
        for (int i = 0; i < NB; i++) if (wbe_v[i]) mmem[wa][8*i +: 8] = wdv[8*i +: 8];
    end
    @(posedge clk);
    #1;
    check("ready", ready, mready);
    check("rvalid", rvalid, exp_rvalid);
    if (rvalid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", rvalid, 1'b0);
      end else begin
        last_rd = sbq.pop_front();
        check("rd", rd, last_rd);
      end
    end else begin
      check("rd_hold", rd, last_rd);
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    cyc(1'b1, 1'b1, be, a, d, 1'b0, '0);
  endtask

  task automatic rd_at(input logic [AW-1:0] a);
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  initial begin
    int  n;
    bit  seen;

    // Reset for two edges, then sweep with requests that must be ignored.
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 1'b1, 4'hF, AW'(i), 32'h5555_5555, 1'b1, AW'(i));
    check("clear_rd_zero", rd, 32'h0);

    for (int i = 0; i < DEPTH; i++) rd_at(AW'(i));

    wr(3'd1, 32'hAAAA_AAAA, 4'hF);
    rd_at(3'd1);
    check("full_wr_lit", rd, 32'hAAAA_AAAA);
    idle();
    rd_at(3'd0);
    check("addr0_lit", rd, 32'h0);

    wr(3'd1, 32'hFFFF_FFFF, 4'b0101);
    rd_at(3'd1);
    check("byte_en_lit", rd, 32'hAAFF_AAFF);
    wr(3'd1, 32'h0123_4567, 4'b0000);
    rd_at(3'd1);
    check("wbe_zero_lit", rd, 32'hAAFF_AAFF);

    wr(3'd2, 32'h1234_5678, 4'hF);
    cyc(1'b1, 1'b1, 4'b1100, 3'd2, 32'hDEAD_BEEF, 1'b1, 3'd2);
    check("collide_lit", rd, 32'hDEAD_5678);
    rd_at(3'd2);
    check("collide_mem_lit", rd, 32'hDEAD_5678);

    cyc(1'b1, 1'b1, 4'hF, 3'd3, 32'hCAFE_F00D, 1'b1, 3'd1);
    check("indep_lit", rd, 32'hAAFF_AAFF);
    rd_at(3'd3);
    check("indep_wr_lit", rd, 32'hCAFE_F00D);

    for (int k = 0; k < 200; k++)
      cyc(1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)), AW'($urandom_range(DEPTH - 1)),
          32'($urandom), 1'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)));
    idle();

    // Reset partway through a sweep must restart it from address 0.
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    for (int k = 0; k < 4; k++) idle();
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    n    = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      idle();
      if (ready === 1'b1) begin
        n    = k;
        seen = 1'b1;
      end
    end
    check("clear_len", n, 8);
    for (int i = 0; i < DEPTH; i++) rd_at(AW'(i));
    idle();
    check("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_dp_be.md
# sram_dp_be

Parametrised successor to the 8×32 DFF SRAM: a one-write-port, one-read-port flip-flop memory with configurable width and depth, per-byte write enables, a registered read with valid flag, write-first bypass on address collision, and a self-clearing initialisation sequencer. It sits behind the datapath as a small register-file/scratch store. The `ready` output tells the upstream logic when the contents are defined and ports are accepted.

## Interface
- `DW`, 32, data width in bits; must be a multiple of 8 (elaboration error otherwise).
- `AW`, 3, address width; `DEPTH = 2**AW` words.
- `NB`, derived `DW/8`, number of byte lanes; not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  synchronous, active-low reset; sampled only on the rising edge of `clk`.
- `we`  in  1  write request.
- `wbe`  in  NB  byte-lane enables; `wbe[i]` selects `wd[8i+7:8i]`.
- `waddr`  in  AW  write address.
- `wd`  in  DW  write data.
- `re`  in  1  read request.
- `raddr`  in  AW  read address.
- `rd`  out  DW  registered read data.
- `rvalid`  out  1  `rd` was updated by a read at the preceding edge.
- `ready`  out  1  initialisation done; requests are accepted only while high.

## Operation
- **State machine:** CLEAR, RUN.
  - Any edge with `resetn=0` forces CLEAR, `clr_addr=0`, `rd=0`, `rvalid=0`, `ready=0`.
  - Memory contents are not touched by the reset edge itself.
- **CLEAR** (with `resetn=1`), on each edge:
  - writes all-zeros to `mem[clr_addr]`, then increments `clr_addr`;
  - on the edge that clears `DEPTH-1`, moves to RUN and sets `ready=1`.
  - `we` and `re` are ignored throughout CLEAR: no write, `rvalid` stays 0, `rd` stays 0.
- **Reset mid-CLEAR:** the sweep restarts from address 0; there is no partial resume.
- **RUN write:** on an edge with `we=1`, only the lanes with `wbe[i]=1` of `mem[waddr]` take `wd`. Other lanes keep their value. `we=1` with `wbe=0` is a legal no-op.
- **RUN read:** on an edge with `re=1`, `rd <= mem[raddr]` and `rvalid <= 1`. With `re=0`, `rvalid <= 0` and `rd` holds its last value.
- **Collision** (`we=1`, `re=1`, `waddr==raddr` at the same edge) is write-first:
  - enabled lanes of `rd` carry the new `wd`;
  - disabled lanes carry the old stored bytes;
  - memory is updated as for a normal write.
- Addresses wrap naturally. Every `AW`-bit value is a valid word, so there is no out-of-range case.
- Write and read to different addresses on the same edge proceed independently.

## Timing
- **Reset values:** `rd=0`, `rvalid=0`, `ready=0`.
- **Clear sweep:** `ready` rises exactly `DEPTH` rising edges after the first edge sampling `resetn=1`. For the default `DEPTH=8`, that is the 8th edge.
- **Read latency:** 1 cycle. `rd`/`rvalid` change at the edge that samples `re`, and are visible for the following cycle. `rvalid` is a one-cycle pulse per accepted read; back-to-back reads give continuous `rvalid`.
- **Write latency:** a write at edge N is visible to a read sampled at edge N (bypass, same address) and at any later edge.
- No combinational path exists from any input to any output.

## Test plan
- **Reset and clear:**
  - Stimulus: hold `resetn=0` for 2 edges, release.
  - Required: `ready=0` for 7 edges and 1 after the 8th; reads of all 8 addresses return `32'h00000000` with `rvalid=1` one cycle after each `re`.
- **Full write/read:**
  - Stimulus: write `32'hAAAAAAAA` to address 1 with `wbe=4'hF`, then `re` at address 1.
  - Required: `rd=32'hAAAAAAAA`, `rvalid=1` for one cycle. Address 0 still reads `32'h0`.
- **Byte enables:**
  - Stimulus: over address 1 holding `32'hAAAAAAAA`, write `32'hFFFFFFFF` with `wbe=4'b0101`, then read address 1.
  - Required: `rd=32'hAAFFAAFF`. A second write with `wbe=4'b0000` leaves the readback unchanged.
- **Collision bypass:**
  - Stimulus: address 2 holds `32'h12345678`; same edge `we=1`, `wbe=4'b1100`, `wd=32'hDEADBEEF`, `re=1`, `raddr=waddr=2`.
  - Required: `rd=32'hDEAD5678` at that edge. A subsequent read returns `32'hDEAD5678`.
- **Requests during CLEAR:**
  - Stimulus: drive `we=1`, `wd=32'h55555555`, `re=1` during the sweep.
  - Required: `rvalid` stays 0, `rd` stays 0, and after `ready` every address reads 0.
- **Reset mid-CLEAR:**
  - Stimulus: assert `resetn=0` for one edge after 4 sweep edges, then release.
  - Required: `ready` rises exactly 8 edges after the re-release, not 4.
